// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// Module : ram_ctrl_pkg
// Brief  : Shared state encoding and default widths for the RAM controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

   localparam int DEFAULT_D_WIDTH = 32;
   localparam int DEFAULT_A_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_ctrl.sv
// ============================================================================
// Module : ram_ctrl
// Brief  : Single-request load/store sequencer for an edge-strobed RAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int D_WIDTH = DEFAULT_D_WIDTH,
   parameter int A_WIDTH = DEFAULT_A_WIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [A_WIDTH-1:0] req_addr,
   input  logic [D_WIDTH-1:0] req_wdata,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic               resp_write,
   output logic [D_WIDTH-1:0] resp_rdata,
   output logic [A_WIDTH-1:0] address_write,
   output logic [D_WIDTH-1:0] data_write,
   output logic               write_enable,
   output logic [A_WIDTH-1:0] address_read,
   output logic               read_enable,
   input  logic [D_WIDTH-1:0] data_read
);

   state_t               state, next_state;
   logic                 req_ready_next;
   logic                 resp_valid_next;
   logic                 resp_write_next;
   logic [D_WIDTH-1:0]   resp_rdata_next;
   logic [A_WIDTH-1:0]   address_write_next;
   logic [D_WIDTH-1:0]   data_write_next;
   logic                 write_enable_next;
   logic [A_WIDTH-1:0]   address_read_next;
   logic                 read_enable_next;

   // Every output is computed here one cycle ahead and registered below,
   // so no input reaches an output without passing through a flop.
   always_comb begin
      next_state         = state;
      req_ready_next     = req_ready;
      resp_valid_next    = resp_valid;
      resp_write_next    = resp_write;
      resp_rdata_next    = resp_rdata;
      address_write_next = address_write;
      data_write_next    = data_write;
      address_read_next  = address_read;
      write_enable_next  = 1'b0;
      read_enable_next   = 1'b0;

      case (state)
         IDLE: begin
            req_ready_next = 1'b1;
            if (req_valid && req_ready) begin
               if (req_write) begin
                  address_write_next = req_addr;
                  data_write_next    = req_wdata;
               end else begin
                  address_read_next  = req_addr;
               end
               resp_write_next = req_write;
               req_ready_next  = 1'b0;
               next_state      = SETUP;
            end
         end
         SETUP: begin
            write_enable_next = resp_write;
            read_enable_next  = ~resp_write;
            next_state        = STROBE;
         end
         STROBE: begin
            // The RAM already presented the word at the strobe's rising edge.
            if (!resp_write) begin
               resp_rdata_next = data_read;
            end
            resp_valid_next = 1'b1;
            next_state      = RESP;
         end
         RESP: begin
            if (resp_valid && resp_ready) begin
               resp_valid_next = 1'b0;
               req_ready_next  = 1'b1;
               next_state      = IDLE;
            end
         end
         default: begin
            resp_valid_next = 1'b0;
            req_ready_next  = 1'b1;
            next_state      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_write    <= 1'b0;
         resp_rdata    <= '0;
         address_write <= '0;
         data_write    <= '0;
         write_enable  <= 1'b0;
         address_read  <= '0;
         read_enable   <= 1'b0;
      end else begin
         state         <= next_state;
         req_ready     <= req_ready_next;
         resp_valid    <= resp_valid_next;
         resp_write    <= resp_write_next;
         resp_rdata    <= resp_rdata_next;
         address_write <= address_write_next;
         data_write    <= data_write_next;
         write_enable  <= write_enable_next;
         address_read  <= address_read_next;
         read_enable   <= read_enable_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ram_ctrl.sv
// ============================================================================
// Module : tb_ram_ctrl
// Brief  : Scoreboard bench for ram_ctrl with a behavioural edge-strobed RAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_ctrl;
   import ram_ctrl_pkg::*;

   localparam int DW = DEFAULT_D_WIDTH;
   localparam int AW = DEFAULT_A_WIDTH;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b1;
   logic          resp_write;
   logic [DW-1:0] resp_rdata;
   logic [AW-1:0] address_write;
   logic [DW-1:0] data_write;
   logic          write_enable;
   logic [AW-1:0] address_read;
   logic          read_enable;
   logic [DW-1:0] data_read = '0;

   ram_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_write(resp_write), .resp_rdata(resp_rdata),
      .address_write(address_write), .data_write(data_write),
      .write_enable(write_enable), .address_read(address_read),
      .read_enable(read_enable), .data_read(data_read)
   );

   always #5 clock = ~clock;

   // Edge-strobed RAM: both ports act on the rising edge of their enable.
   logic [DW-1:0] ram [16];
   always @(posedge write_enable) ram[address_write] <= data_write;
   always @(posedge read_enable)  data_read <= ram[address_read];

   int passed = 0;
   int total  = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   typedef struct {
      logic          wr;
      logic [DW-1:0] rdata;
      int            acc;
   } exp_t;

   exp_t          sbq[$];
   logic [DW-1:0] mdl_mem [16];
   logic [DW-1:0] last_load = '0;
   int            cyc = 0;
   int            last_acc = -100;

   always @(posedge clock) cyc <= cyc + 1;

   // Protocol monitor and scoreboard consumer, sampling on the falling edge.
   logic prev_we = 1'b0, prev_re = 1'b0, prev_rv = 1'b0;
   int   we_low = 10, re_low = 10;
   always @(negedge clock) begin
      if (!reset) begin
         if (write_enable || read_enable)
            check_eq("en_overlap", 64'(write_enable && read_enable), 0);
         if (write_enable) begin
            check_eq("we_width", 64'(prev_we), 0);
            check_eq("we_rise_time", 64'(cyc - last_acc), 1);
            check_eq("we_gap", 64'(we_low >= 2), 1);
         end
         if (read_enable) begin
            check_eq("re_width", 64'(prev_re), 0);
            check_eq("re_rise_time", 64'(cyc - last_acc), 1);
            check_eq("re_gap", 64'(re_low >= 2), 1);
         end
         if (resp_valid && !prev_rv) begin
            if (sbq.size() == 0) check_eq("resp_unexpected", 1, 0);
            else check_eq("resp_latency", 64'(cyc - sbq[0].acc), 2);
         end
         if (resp_valid && resp_ready && sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check_eq("resp_write", 64'(resp_write), 64'(e.wr));
            check_eq("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
         end
      end
      we_low  = write_enable ? 0 : we_low + 1;
      re_low  = read_enable  ? 0 : re_low + 1;
      prev_we = write_enable;
      prev_re = read_enable;
      prev_rv = resp_valid;
   end

   task automatic do_req(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit push_exp);
      bit ok;
      ok = 0;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      for (int n = 0; n < 50; n++) begin
         @(negedge clock);
         if (req_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         check_eq("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      last_acc  = cyc;
      if (push_exp) begin
         if (wr) begin
            mdl_mem[a] = d;
            sbq.push_back('{wr: 1'b1, rdata: last_load, acc: cyc});
         end else begin
            last_load = mdl_mem[a];
            sbq.push_back('{wr: 1'b0, rdata: last_load, acc: cyc});
         end
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if (sbq.size() == 0 && req_ready) begin ok = 1; break; end
      end
      if (!ok) check_eq("drain_timeout", 0, 1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev_acc;
      for (int i = 0; i < 16; i++) begin
         mdl_mem[i] = '0;
         ram[i]     = '0;
      end

      // Reset release and quiet idle
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check_eq("rst_req_ready", 64'(req_ready), 1);
      check_eq("rst_outputs", {resp_valid, resp_write, write_enable, read_enable},
               4'b0000);
      check_eq("rst_resp_rdata", 64'(resp_rdata), 0);
      check_eq("rst_ram_bus", {address_write, address_read, data_write}, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check_eq("idle_enables", {write_enable, read_enable}, 0);
      end
      @(posedge clock);
      #1;

      // Single store, then load of the same address
      do_req(1'b1, 4'd3, 32'hDEADBEEF, 1);
      check_eq("store_addr", 64'(address_write), 3);
      check_eq("store_data", 64'(data_write), 64'h0000_0000_DEAD_BEEF);
      drain();
      do_req(1'b0, 4'd3, 32'h0, 1);
      check_eq("load_addr", 64'(address_read), 3);
      drain();

      // Backpressure on a load, with stray req_valid pulses
      resp_ready = 1'b0;
      do_req(1'b0, 4'd3, 32'h0, 1);
      for (int k = 0; k < 7; k++) begin
         @(negedge clock);
         if (cyc - last_acc >= 2) begin
            check_eq("bp_resp_valid", 64'(resp_valid), 1);
            check_eq("bp_resp_rdata", 64'(resp_rdata), 64'h0000_0000_DEAD_BEEF);
         end
         check_eq("bp_req_ready", 64'(req_ready), 0);
         req_valid = k[0]; req_write = 1'b1; req_addr = 4'd3; req_wdata = 32'h0BAD_0BAD;
      end
      @(posedge clock);
      #1;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      check_eq("bp_complete", 64'(resp_valid), 0);
      check_eq("bp_req_ready_back", 64'(req_ready), 1);
      check_eq("bp_no_stray_store", 64'(ram[3]), 64'h0000_0000_DEAD_BEEF);

      // Streaming stores then loads at full rate
      prev_acc = 0;
      for (int i = 0; i < 32; i++) begin
         logic [AW-1:0] a;
         a = AW'(i % 16);
         if (i < 16) do_req(1'b1, a, 32'h01010101 * i, 1);
         else        do_req(1'b0, a, 32'h0, 1);
         if (i > 0) check_eq("accept_period", 64'(last_acc - prev_acc), 4);
         prev_acc = last_acc;
      end
      drain();

      // Reset during STROBE of a store: RAM written, no response
      do_req(1'b1, 4'd5, 32'h12345678, 0);
      @(posedge clock);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check_eq("strobe_rst_we", 64'(write_enable), 0);
      check_eq("strobe_rst_rv", 64'(resp_valid), 0);
      mdl_mem[5] = 32'h12345678;
      last_load  = '0;
      @(posedge clock);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check_eq("strobe_rst_no_resp", 64'(resp_valid), 0);
      end
      @(posedge clock);
      #1;
      do_req(1'b0, 4'd5, 32'h0, 1);
      drain();

      // Reset during SETUP of a store: RAM untouched
      do_req(1'b1, 4'd5, 32'hCAFEF00D, 0);
      #3 reset = 1'b1;
      #1;
      check_eq("setup_rst_we", 64'(write_enable), 0);
      last_load = '0;
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      do_req(1'b0, 4'd5, 32'h0, 1);
      drain();
      check_eq("sb_empty", 64'(sbq.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
